uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal values are >= 2.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; legal values are powers of two >= 2.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wrreq  input  1  byte write strobe from the memory-mapped I/O side, one byte per asserted cycle.
REQ-006 SHALL have port wrdata  input  8  byte to enqueue, sampled with wrreq.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port txd  output  1  serial line; idle high; registered output.

Function
REQ-011 SHALL enqueue wrdata on a rising edge where wrreq=1 and full=0.
REQ-012 SHALL silently drop a write where wrreq=1 and full=1, even if a pop occurs in the same cycle; count SHALL be unchanged by the dropped write.
REQ-013 SHALL, on a same-cycle enqueue and pop with 0<count<DEPTH, leave count unchanged and preserve FIFO order.
REQ-014 SHALL use the FSM states IDLE, START, DATA and STOP, held in a registered state variable.
REQ-015 SHALL, in IDLE with count>0, pop the head byte into an 8-bit shift register, enter START and drive txd=0 on that same edge.
REQ-016 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-017 SHALL, in DATA, send the 8 data bits LSB first, tracked by a 3-bit index, then enter STOP.
REQ-018 SHALL, in STOP, drive txd=1 for one bit time (8N1 framing; total frame is 10*CLKS_PER_BIT cycles).
REQ-019 SHALL, at the end of STOP with count>0, pop and enter START directly with no idle cycle; with count=0 it SHALL enter IDLE.
REQ-020 SHALL give a latency of 1 edge: a byte written into an empty FIFO while IDLE at edge E produces txd low from edge E+1.
REQ-021 SHALL compute busy = (state!=IDLE) | (count!=0).
REQ-022 SHALL wrap the FIFO read and write pointers modulo DEPTH; full and count SHALL derive from pointers that are one bit wider than the address.
REQ-023 SHALL NOT abort or alter an in-progress frame because of FIFO writes.

Reset
REQ-024 SHALL, while rst_n=0, force txd=1, state=IDLE, count=0, full=0, busy=0, clear the pointers, the baud counter and the bit index, with no clk edge required.
REQ-025 SHALL discard a frame that is in progress when reset asserts; txd SHALL return high immediately and SHALL NOT resume the frame after reset.
REQ-026 SHALL treat the first rising edge after rst_n deassertion as a normal operating edge.

Structure
REQ-027 SHALL place the state enum (IDLE/START/DATA/STOP) and the default CLKS_PER_BIT constant in shared package uart_pkg.
REQ-028 SHALL implement storage as sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count); serializer logic SHALL stay in uart_tx_fifo.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-029 SHALL cover single byte: write 0xA5 while idle -> txd from the next edge is 0,1,0,1,0,0,1,0,1,1 (start bit, data LSB first, stop bit), 4 cycles per bit; busy falls after 40 cycles.
REQ-030 SHALL cover back-to-back frames: write 0x00 then 0xFF on consecutive cycles -> two contiguous 40-cycle frames with no idle gap; count goes 1,1,0 across the pops.
REQ-031 SHALL cover overflow: while a frame is active, write 0x11,0x22,0x33,0x44,0x55 -> full=1 after the fourth write; 0x55 is dropped; the output order is 0x11,0x22,0x33,0x44.
REQ-032 SHALL cover simultaneous events: with count=2, issue a write coincident with the end of STOP -> count stays 2; all bytes are sent in write order.
REQ-033 SHALL cover reset mid-frame: assert rst_n=0 during bit 3 of 0x3C -> txd=1 asynchronously, count=0; after release txd stays high until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // 50 MHz system clock, 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; writes while full are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        count   = wptr_q - rptr_q;
        full    = (count == (AW+1)'(DEPTH));
        empty   = (wptr_q == rptr_q);
        // a full FIFO refuses the write even when a pop frees a slot
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wptr_d  = wptr_q + (AW+1)'(do_push);
        rptr_d  = rptr_q + (AW+1)'(do_pop);
        dout    = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a byte FIFO written by the MMIO side.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wrreq,
    input  logic [7:0]             wrdata,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   txd
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic          txd_q, txd_d;
    logic          pop;
    logic          empty;
    logic          bit_end;
    logic [7:0]    head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wrreq),
        .pop   (pop),
        .din   (wrdata),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        bit_end = (baud_q == BAUD_LAST);
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    baud_d  = '0;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    txd_d   = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        txd_d   = shreg_q[1];
                    end
                end
            end
            STOP: begin
                // chain straight into the next start bit when data waits
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = head;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            baud_q  <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != IDLE) | (count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wrreq = 1'b0;
    logic [7:0] wrdata = 8'h00;
    logic       full;
    logic       busy;
    logic       txd;
    logic [2:0] count;

    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         starts_q[$];
    bit         rst_seen = 1'b0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrreq  (wrreq),
        .wrdata (wrdata),
        .full   (full),
        .count  (count),
        .busy   (busy),
        .txd    (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge rst_n) rst_seen = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit accepted);
        @(negedge clk);
        wrreq  = 1'b1;
        wrdata = b;
        if (accepted) exp_q.push_back(b);
        @(posedge clk);
        #1;
        wrreq = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_idle_in_time"}, int'(n < 2000), 1);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    // decodes one frame per falling start edge, sampling mid-bit
    initial begin : monitor
        logic [9:0] fr;
        int         t0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) begin
                rst_seen = 1'b0;
                t0 = cyc;
                repeat (2) @(negedge clk);
                fr[0] = txd;
                for (int i = 1; i < 10; i++) begin
                    repeat (4) @(negedge clk);
                    fr[i] = txd;
                end
                if (!rst_seen) begin
                    starts_q.push_back(t0);
                    chk("start_bit", int'(fr[0]), 0);
                    chk("stop_bit", int'(fr[9]), 1);
                    chk("frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        chk("frame_byte", int'(fr[8:1]), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int a5_seq[10];
        int s0;
        int low;
        a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", int'(txd), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single byte, exact waveform
        wr(8'hA5, 1'b1);
        chk("a5_count_at_write", int'(count), 1);
        chk("a5_txd_high_at_write", int'(txd), 1);
        chk("a5_busy_at_write", int'(busy), 1);
        @(posedge clk);
        #1;
        chk("a5_popped", int'(count), 0);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("a5_bit%0d_c%0d", k, c), int'(txd), a5_seq[k]);
                if (k == 9 && c == CPB - 1) chk("a5_busy_last", int'(busy), 1);
                @(posedge clk);
                #1;
            end
        end
        chk("a5_busy_after_frame", int'(busy), 0);
        chk("a5_txd_idle", int'(txd), 1);
        wait_idle("a5");

        // back-to-back frames without a gap
        s0 = starts_q.size();
        wr(8'h00, 1'b1);
        chk("b2b_count_1", int'(count), 1);
        wr(8'hFF, 1'b1);
        chk("b2b_count_2", int'(count), 1);
        repeat (39) @(posedge clk);
        #1;
        chk("b2b_count_before_pop", int'(count), 1);
        @(posedge clk);
        #1;
        chk("b2b_count_after_pop", int'(count), 0);
        chk("b2b_busy", int'(busy), 1);
        wait_idle("b2b");
        chk("b2b_frames", starts_q.size() - s0, 2);
        if (starts_q.size() >= s0 + 2) begin
            chk("b2b_gap", starts_q[s0+1] - starts_q[s0], 10 * CPB);
        end

        // overflow while a frame is active
        wr(8'h5A, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        wr(8'h33, 1'b1);
        chk("ovf_not_full_3", int'(full), 0);
        wr(8'h44, 1'b1);
        chk("ovf_full_4", int'(full), 1);
        chk("ovf_count_4", int'(count), 4);
        wr(8'h55, 1'b0);
        chk("ovf_count_drop", int'(count), 4);
        chk("ovf_full_drop", int'(full), 1);
        wait_idle("ovf");

        // write coinciding with the end of STOP while count is 2
        s0 = starts_q.size();
        wr(8'h81, 1'b1);
        wr(8'h42, 1'b1);
        wr(8'h24, 1'b1);
        chk("sim_count_2", int'(count), 2);
        repeat (38) @(posedge clk);
        #1;
        chk("sim_count_pre", int'(count), 2);
        wr(8'h99, 1'b1);
        chk("sim_count_post", int'(count), 2);
        wait_idle("sim");
        chk("sim_frames", starts_q.size() - s0, 4);
        if (starts_q.size() >= s0 + 2) begin
            chk("sim_gap", starts_q[s0+1] - starts_q[s0], 10 * CPB);
        end

        // reset during data bit 3 of 0x3C
        wr(8'h3C, 1'b0);
        wr(8'h77, 1'b0);
        chk("rstm_count_pre", int'(count), 1);
        repeat (17) @(posedge clk);
        #1;
        chk("rstm_busy_pre", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstm_txd", int'(txd), 1);
        chk("rstm_count", int'(count), 0);
        chk("rstm_busy", int'(busy), 0);
        chk("rstm_full", int'(full), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        low = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1 || busy !== 1'b0) low++;
        end
        chk("rstm_stays_idle", low, 0);
        wr(8'hC3, 1'b1);
        @(posedge clk);
        #1;
        chk("rstm_restart_txd", int'(txd), 0);
        wait_idle("rstm");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
